// File: rtl/uart_rx_pack.sv
// UART receiver that packs bytes into words and buffers them in a FIFO.
// Optional echo transmitter enabled by defining UART_ECHO_EN.
module uart_rx_pack #(
  parameter int CLK_DIV    = 434,
  parameter int WORD_BYTES = 4,
  parameter int DEPTH_LOG2 = 4,
  parameter int PARITY     = 0
) (
  input  logic                    clk_50_0,
  input  logic                    reset,
  input  logic                    rx,
  output logic                    tx,
  input  logic                    rd_en,
  output logic [8*WORD_BYTES-1:0] rd_data,
  output logic                    rd_valid,
  input  logic                    flush,
  output logic                    empty,
  output logic                    full,
  output logic [DEPTH_LOG2:0]     level,
  output logic                    frame_err,
  output logic                    par_err,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int CW    = $clog2(CLK_DIV);
  localparam int WW    = 8 * WORD_BYTES;
  localparam int LW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_par;
  logic          r_wait;

  logic w_fall, w_half, w_full, w_stop_smp;
  logic w_par_bad, w_good;

  assign w_fall = r_rx_prev & ~r_rx_s2;
  assign w_half = r_cnt == CW'(CLK_DIV / 2 - 1);
  assign w_full = r_cnt == CW'(CLK_DIV - 1);
  assign w_stop_smp = (r_state == S_STOP) && !r_wait && w_full;

  always_comb begin
    w_par_bad = 1'b0;
    if (PARITY == 1) w_par_bad = ~(^{r_sh, r_par});
    if (PARITY == 2) w_par_bad = ^{r_sh, r_par};
  end

  assign w_good = w_stop_smp && r_rx_s2 && !w_par_bad;

  // Sync flops reset low so a line held low at release is not an edge.
  always_ff @(posedge clk_50_0) begin
    if (reset) begin
      r_rx_s1   <= 1'b0;
      r_rx_s2   <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  always_ff @(posedge clk_50_0) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_sh      <= '0;
      r_par     <= 1'b0;
      r_wait    <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      frame_err <= w_stop_smp && !r_rx_s2;
      par_err   <= w_stop_smp && w_par_bad;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_rx_s2 ? S_IDLE : S_DATA;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_DATA: begin
          if (w_full) begin
            r_cnt <= '0;
            r_sh  <= {r_rx_s2, r_sh[7:1]};
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7)
              r_state <= (PARITY == 0) ? S_STOP : S_PAR;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_PAR: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_par   <= r_rx_s2;
            r_state <= S_STOP;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_STOP: begin
          if (r_wait) begin
            if (r_rx_s2) begin
              r_wait  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (w_full) begin
            r_cnt <= '0;
            if (!r_rx_s2) r_wait <= 1'b1;
            else r_state <= S_IDLE;
          end else r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic [WW-1:0] r_pack, r_push_data, w_ins;
  logic [LW-1:0] r_lane;
  logic          r_push, w_push_now;

  always_comb begin
    w_ins = r_pack;
    if (w_good) w_ins[8*r_lane +: 8] = r_sh;
  end

  assign w_push_now = w_good
    ? ((r_lane == LW'(WORD_BYTES - 1)) || flush)
    : (flush && (r_lane != '0));

  always_ff @(posedge clk_50_0) begin
    if (reset) begin
      r_pack      <= '0;
      r_lane      <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= w_push_now;
      if (w_push_now) begin
        r_push_data <= w_ins;
        r_pack      <= '0;
        r_lane      <= '0;
      end else if (w_good) begin
        r_pack <= w_ins;
        r_lane <= r_lane + 1'b1;
      end
    end
  end

  logic [WW-1:0]         r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp, r_rp;
  logic                  w_do_pop, w_do_push, w_drop;

  assign empty     = level == '0;
  assign full      = level == (DEPTH_LOG2 + 1)'(DEPTH);
  assign w_do_pop  = rd_en && !empty;
  assign w_do_push = r_push && (!full || w_do_pop);
  assign w_drop    = r_push && full && !w_do_pop;

  always_ff @(posedge clk_50_0) begin
    if (w_do_push) r_mem[r_wp] <= r_push_data;
  end

  always_ff @(posedge clk_50_0) begin
    if (reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= w_do_pop;
      if (w_do_pop) begin
        rd_data <= r_mem[r_rp];
        r_rp    <= r_rp + 1'b1;
      end
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_push && !w_do_pop) level <= level + 1'b1;
      else if (!w_do_push && w_do_pop) level <= level - 1'b1;
      if (w_drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef UART_ECHO_EN
  logic [9:0]    r_tx_sh;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bits;
  logic          r_tx_busy;
  logic [7:0]    r_eq0, r_eq1;
  logic [1:0]    r_eq_n, w_pos;
  logic          w_deq, w_enq;

  assign tx    = r_tx_sh[0];
  assign w_deq = !r_tx_busy && (r_eq_n != 2'd0);
  assign w_enq = w_good && ((r_eq_n != 2'd2) || w_deq);
  assign w_pos = r_eq_n - {1'b0, w_deq};

  always_ff @(posedge clk_50_0) begin
    if (reset) begin
      r_tx_sh   <= '1;
      r_tx_cnt  <= '0;
      r_tx_bits <= '0;
      r_tx_busy <= 1'b0;
      r_eq0     <= '0;
      r_eq1     <= '0;
      r_eq_n    <= '0;
    end else begin
      if (w_deq) begin
        r_tx_sh   <= {1'b1, r_eq0, 1'b0};
        r_tx_busy <= 1'b1;
        r_tx_bits <= '0;
        r_tx_cnt  <= '0;
        r_eq0     <= r_eq1;
      end else if (r_tx_busy) begin
        if (r_tx_cnt == CW'(CLK_DIV - 1)) begin
          r_tx_cnt  <= '0;
          r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
          r_tx_bits <= r_tx_bits + 1'b1;
          if (r_tx_bits == 4'd9) r_tx_busy <= 1'b0;
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
      end
      if (w_enq) begin
        if (w_pos == 2'd0) r_eq0 <= r_sh;
        else r_eq1 <= r_sh;
      end
      r_eq_n <= r_eq_n + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end
`else
  assign tx = 1'b1;
`endif

endmodule

// File: doc/uart_rx_pack.md
UART_RX_PACK -- requirements
Module: uart_rx_pack

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 434, clocks per UART bit (minimum 4).
REQ-002 The module SHALL have parameter WORD_BYTES, default 4, bytes packed per stored word (1..4).
REQ-003 The module SHALL have parameter DEPTH_LOG2, default 4, log2 of buffer depth in words.
REQ-004 The module SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 The module SHALL have port clk_50_0, input, 1 bit, sole clock; one clock; reset is synchronous and active-high.
REQ-006 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 The module SHALL have port rx, input, 1 bit, asynchronous UART serial input, idle high.
REQ-008 The module SHALL have port tx, output, 1 bit, UART serial output.
REQ-009 The module SHALL have port rd_en, input, 1 bit, pop request.
REQ-010 The module SHALL have port rd_data, output, 8*WORD_BYTES bits, popped word.
REQ-011 The module SHALL have port rd_valid, output, 1 bit, rd_data valid strobe.
REQ-012 The module SHALL have port flush, input, 1 bit, push the partial word now.
REQ-013 The module SHALL have ports empty, full, level[DEPTH_LOG2:0], outputs, buffer status.
REQ-014 The module SHALL have ports frame_err, par_err, outputs, 1-cycle error pulses.
REQ-015 The module SHALL have port overflow, output, 1 bit, sticky lost-word flag; and ovf_clr, input, 1 bit, which clears it.

Function
REQ-016 rx SHALL pass through a 2-flop synchroniser before any use.
REQ-017 Receive FSM SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-018 IDLE->START on synchronised falling edge; START samples at CLK_DIV/2; high there SHALL return to IDLE (glitch, nothing reported).
REQ-019 DATA SHALL sample 8 bits LSB-first, each CLK_DIV clocks after the previous sample.
REQ-020 Parity mismatch SHALL discard the byte and pulse par_err for one cycle at the stop-bit sample.
REQ-021 Stop bit sampled low SHALL discard the byte, pulse frame_err, and return to IDLE only after rx is high.
REQ-022 A good byte SHALL be placed in byte lane n (bits 8n+7:8n) of the packing register, n counting from 0.
REQ-023 When lane WORD_BYTES-1 fills, the word SHALL be pushed in the cycle after the stop-bit sample; the lane counter SHALL wrap to 0.
REQ-024 flush with ≥1 byte pending SHALL push the partial word with unfilled lanes zero; with 0 bytes pending, flush SHALL have no effect.
REQ-025 A flush coinciding with a byte completion SHALL include that byte.
REQ-026 Push while full and no pop that cycle SHALL drop the word and set overflow; buffer contents SHALL be unchanged.
REQ-027 Push and pop in the same cycle while full SHALL both succeed; level SHALL be unchanged.
REQ-028 rd_en while empty SHALL be ignored: no pointer change, rd_valid stays 0.
REQ-029 rd_en while not empty SHALL yield rd_data and rd_valid=1 on the next cycle (1-cycle latency); rd_data SHALL hold its value between pops.
REQ-030 empty SHALL deassert the cycle after a push into an empty buffer; pointers SHALL wrap modulo 2^DEPTH_LOG2.
REQ-031 ovf_clr SHALL clear overflow unless a drop occurs in the same cycle, in which case overflow stays set.

Reset
REQ-032 reset SHALL force the FSM to IDLE, clear pointers, level, lane counter and packing register, and set empty=1, full=0, overflow=0, rd_valid=0, rd_data=0, frame_err=0, par_err=0, tx=1.
REQ-033 reset mid-frame SHALL abandon the frame; reception SHALL restart only on a new falling edge after reset is released.

Configuration
REQ-034 With UART_ECHO_EN defined, each good byte SHALL be retransmitted on tx (8N1 at CLK_DIV) starting within 2 cycles of acceptance, with a 2-byte echo queue; excess bytes are not echoed but are still stored.
REQ-035 Without UART_ECHO_EN, tx SHALL be constant 1 and no transmitter logic SHALL exist.

Verification (CLK_DIV=8, WORD_BYTES=4, DEPTH_LOG2=2, PARITY=0)
REQ-036 Bytes 0x11,0x22,0x33,0x44 sent, then rd_en pulse -> next cycle rd_valid=1, rd_data=0x44332211, empty=1 afterwards.
REQ-037 Byte 0xA5 with stop bit low -> frame_err one pulse, level stays 0; next good byte stored normally.
REQ-038 0x01,0x02 then flush -> one word 0x00000201, level=1.
REQ-039 20 good bytes (5 words), no reads -> level=4, full=1, overflow=1; ovf_clr -> overflow=0; reads return words 1..4 in order.
REQ-040 rx low pulse of 3 clocks -> no byte, no error, FSM back in IDLE; reset asserted mid-DATA -> all outputs at reset values.
REQ-041 PARITY=2, byte 0x03 sent with parity bit 1 -> par_err pulse, nothing stored; with UART_ECHO_EN, 0x5A received -> 0x5A observed on tx.
